mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter that shares one synchronous RAM between the core's instruction-fetch port and its load/store data port. It sits between `core` and the unified memory model. It serialises requests with a fixed data-over-fetch priority plus a starvation guard. It runs one transaction at a time through a small FSM with a parameterised memory read latency.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes
- `LATENCY`, 1, memory read latency in cycles from `mem_en` cycle to valid `mem_rdata` (legal ≥1)
- `STARVE_LIMIT`, 4, consecutive contested data grants before fetch is forced (legal ≥1)

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge
- `reset` in 1: synchronous, active-high
- `i_req_valid` in 1 / `i_req_ready` out 1 / `i_req_addr` in `ADDR_W`: fetch request
- `i_rsp_valid` out 1 / `i_rsp_data` out `DATA_W`: fetch response
- `d_req_valid` in 1 / `d_req_ready` out 1 / `d_req_addr` in `ADDR_W`: data request
- `d_req_we` in 1 / `d_req_wdata` in `DATA_W` / `d_req_wstrb` in `DATA_W/8`: data write controls
- `d_rsp_valid` out 1 / `d_rsp_data` out `DATA_W`: data response
- `mem_en` out 1 / `mem_we` out 1 / `mem_addr` out `ADDR_W` / `mem_wdata` out `DATA_W` / `mem_wstrb` out `DATA_W/8`: RAM command
- `mem_rdata` in `DATA_W`: RAM read data

## Operation
- **Handshake:** a request is accepted in a cycle where valid and ready are both 1. Requesters hold valid, address and write fields stable until accepted. Ready is combinational: nonzero only in IDLE and only for the granted port. At most one ready is high per cycle.
- **Grant in IDLE:**
  - Only one valid: that port wins.
  - Both valid: data wins unless `streak == STARVE_LIMIT`, in which case fetch wins.
- **streak counter:**
  - Increments (saturating) on a data grant while fetch was also valid.
  - Clears on any fetch grant.
  - Unchanged on an uncontested data grant.
- **FSM states** (IDLE, ISSUE, WAIT, RESP):
  - IDLE → ISSUE on accept. Register owner, addr, we, wdata, wstrb. Fetch requests register as we=0 and wstrb=0.
  - ISSUE (1 cycle) → WAIT. Drive `mem_en`=1 and the registered command; `mem_we` = registered we. Load `cnt = LATENCY-1`.
  - WAIT: if `cnt==0`, capture `mem_rdata` (forced to 0 for writes) and go to RESP; else decrement.
  - RESP (1 cycle) → IDLE. Pulse the owner's `*_rsp_valid` with captured data.
- Writes also return a `d_rsp_valid` pulse as an acknowledge, with `d_rsp_data`=0.
- A write with `d_req_wstrb`=0 is still issued (`mem_we`=1, zero strobes).
- `mem_we` is never 1 without `mem_en`. `mem_addr`, `mem_wdata` and `mem_wstrb` hold their last value outside ISSUE.
- `*_rsp_data` holds until the next RESP of the same port.

## Timing
- **Reset values:** state IDLE, streak 0, cnt 0. All `*_rsp_valid`, `*_rsp_data`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_wstrb` are 0. Both readys are 0 during any cycle with `reset`=1.
- **Per-transaction cycles** (accept at T):
  - ISSUE at T+1.
  - `mem_rdata` sampled at end of T+1+LATENCY.
  - Response pulse at T+2+LATENCY.
  - Earliest next accept at T+3+LATENCY.
- **Throughput:** one transaction per LATENCY+3 cycles.
- **Reset mid-transaction:** the transaction is dropped. No response pulse is issued, and `mem_en` is 0 from the next cycle. The requester re-presents after reset.
- **Simultaneous events:** a new request arriving during RESP is not accepted until the following IDLE cycle. Streak evaluation uses valids in the accept cycle only.

## Structure
- Shared header `mem_arb_defs.vh`, brought in with `` `include ``. It holds the FSM state encodings (2-bit localparams) and the owner encoding (0 = fetch, 1 = data), for testbench probing.
- Natural sub-module `mem_arb_pick`: combinational grant plus the registered streak counter with `STARVE_LIMIT`.
- FSM, latency counter and response registers stay in `mem_arbiter`.

## Test plan
- **Single fetch:** LATENCY=1, `i_req_valid` at cycle 0, addr 0x10, RAM returns 0x00500093.
  - `i_req_ready`=1 at cycle 0.
  - `mem_en`=1 with `mem_addr`=0x10 at cycle 1.
  - `i_rsp_valid`=1 with data 0x00500093 at cycle 3.
  - Next accept possible at cycle 4.
- **Data write:** LATENCY=1, addr 0x100, wdata 0xDEADBEEF, wstrb 0xF.
  - `mem_we`=1 at cycle 1.
  - `d_rsp_valid`=1 with data 0 at cycle 3.
  - `i_rsp_valid` stays 0.
- **Contention:** both valid every cycle, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I. Readys are never both 1.
- **Latency=3:** single load accepted at 0 → `mem_en` at 1, response at 5, next accept at 6.
- **Reset mid-op:** `reset` asserted during WAIT.
  - No `rsp_valid`, `mem_en`=0 after reset, state IDLE, streak 0.
  - A fresh fetch completes normally afterwards.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the memory arbiter: FSM state encodings and the
// owner encoding. The bench imports these as well, so it can probe the
// FSM state and the transaction owner by name.
package mem_arbiter_pkg;

  // One transaction at a time:
  // accept in IDLE, one command cycle in ISSUE, latency count in WAIT,
  // one response pulse in RESP.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Records which port owns the transaction in flight.
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick
// Grant selection for the arbiter, together with the starvation streak counter.
// Data normally wins over fetch. When data has won STARVE_LIMIT contested
// grants in a row, fetch is forced through once.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   i_fetchValid    - fetch port has a request pending
//   i_dataValid     - data port has a request pending
//   i_idle          - arbiter FSM is in IDLE and can accept a request
//   o_grantFetch    - fetch ready (combinational)
//   o_grantData     - data ready (combinational)
module mem_arbiter_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_fetchValid,
  input  logic i_dataValid,
  input  logic i_idle,
  output logic o_grantFetch,
  output logic o_grantData
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

  logic [STREAK_W-1:0] r_streak;
  logic                w_fetchWins;

  // Fetch wins when it is the only requester, or when the streak has
  // saturated. A grant implies the matching valid, so a grant is also an
  // accept. Both grants are held low while reset is asserted.
  always_comb begin
    w_fetchWins  = i_fetchValid && (!i_dataValid || (r_streak == STREAK_W'(STARVE_LIMIT)));
    o_grantFetch = i_idle && !reset && w_fetchWins;
    o_grantData  = i_idle && !reset && i_dataValid && !w_fetchWins;
  end

  // The streak counts only data grants that beat a waiting fetch.
  // Any fetch grant resets the streak to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (o_grantFetch) begin
      r_streak <= '0;
    end else if (o_grantData && i_fetchValid && (r_streak != STREAK_W'(STARVE_LIMIT))) begin
      r_streak <= r_streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one synchronous RAM between the instruction-fetch port and the
// load/store data port. Exactly one transaction is in flight at a time.
//
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   i_req_valid/ready/addr              - fetch request handshake
//   i_rsp_valid/data                    - fetch response pulse and held data
//   d_req_valid/ready/addr/we/wdata/wstrb - data request handshake
//   d_rsp_valid/data                    - data response pulse (0 data on writes)
//   mem_en/we/addr/wdata/wstrb          - RAM command, driven during ISSUE
//   mem_rdata                           - RAM read data, LATENCY cycles after mem_en
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t              r_state;
  logic                r_owner;
  logic                r_we;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_memEn;
  logic                r_memWe;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [DATA_W-1:0]   r_memWdata;
  logic [STRB_W-1:0]   r_memWstrb;
  logic                r_iRspValid;
  logic [DATA_W-1:0]   r_iRspData;
  logic                r_dRspValid;
  logic [DATA_W-1:0]   r_dRspData;
  logic                w_idle;
  logic                w_grantFetch;
  logic                w_grantData;

  assign w_idle = (r_state == ST_IDLE);

  mem_arbiter_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk          (clk),
    .reset        (reset),
    .i_fetchValid (i_req_valid),
    .i_dataValid  (d_req_valid),
    .i_idle       (w_idle),
    .o_grantFetch (w_grantFetch),
    .o_grantData  (w_grantData)
  );

  assign i_req_ready = w_grantFetch;
  assign d_req_ready = w_grantData;
  assign mem_en      = r_memEn;
  assign mem_we      = r_memWe;
  assign mem_addr    = r_memAddr;
  assign mem_wdata   = r_memWdata;
  assign mem_wstrb   = r_memWstrb;
  assign i_rsp_valid = r_iRspValid;
  assign i_rsp_data  = r_iRspData;
  assign d_rsp_valid = r_dRspValid;
  assign d_rsp_data  = r_dRspData;

  // Transaction FSM. The command registers double as the RAM outputs. They
  // are loaded on accept, so they are valid during ISSUE and then keep their
  // value afterwards. mem_en, mem_we and the response valids are pulses that
  // default to 0 on every cycle. A reset drops any transaction in flight,
  // and no response is produced for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWNER_FETCH;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_memEn     <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_memWstrb  <= '0;
      r_iRspValid <= 1'b0;
      r_iRspData  <= '0;
      r_dRspValid <= 1'b0;
      r_dRspData  <= '0;
    end else begin
      r_memEn     <= 1'b0;
      r_memWe     <= 1'b0;
      r_iRspValid <= 1'b0;
      r_dRspValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grantData) begin
            r_owner    <= OWNER_DATA;
            r_we       <= d_req_we;
            r_memAddr  <= d_req_addr;
            r_memWdata <= d_req_wdata;
            r_memWstrb <= d_req_wstrb;
            r_memEn    <= 1'b1;
            r_memWe    <= d_req_we;
            r_state    <= ST_ISSUE;
          end else if (w_grantFetch) begin
            // A fetch is always a read with no write data or strobes.
            r_owner    <= OWNER_FETCH;
            r_we       <= 1'b0;
            r_memAddr  <= i_req_addr;
            r_memWdata <= '0;
            r_memWstrb <= '0;
            r_memEn    <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= CNT_W'(LATENCY - 1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            // A write is acknowledged with zero data, whatever the RAM returns.
            if (r_owner == OWNER_DATA) begin
              r_dRspData  <= r_we ? '0 : mem_rdata;
              r_dRspValid <= 1'b1;
            end else begin
              r_iRspData  <= mem_rdata;
              r_iRspValid <= 1'b1;
            end
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
